// File: rtl/exp_series_engine.sv
// Fixed-point Taylor-series engine for exp/cosh/sinh. Each term takes three
// cycles (multiply by x, multiply by 1/n, accumulate) and shares one multiplier.
module exp_series_engine #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FRAC      = 12,
    parameter int unsigned MAX_TERMS = 16,
    parameter int unsigned TW        = $clog2(MAX_TERMS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [1:0]              mode,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic [TW-1:0]           terms_in,
    output logic                    busy,
    output logic                    done,
    output logic signed [WIDTH-1:0] result,
    output logic                    ovf
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StMulX,
        StMulC,
        StAcc,
        StDone
    } state_e;

    localparam int unsigned RecipDepth = 1 << TW;
    localparam logic signed [WIDTH-1:0] One =
        {{(WIDTH - FRAC - 1){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic signed [WIDTH-1:0] WordMax = {1'b0, {(WIDTH - 1){1'b1}}};
    localparam logic signed [WIDTH-1:0] WordMin = {1'b1, {(WIDTH - 1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] ProdMax =
        {{(WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] ProdMin =
        {{(WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

    state_e                  state_q, state_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic [1:0]              mode_q, mode_d;
    logic [TW-1:0]           nlim_q, nlim_d;
    logic [TW-1:0]           n_q, n_d;
    logic signed [WIDTH-1:0] t_q, t_d;
    logic signed [WIDTH-1:0] acc_q, acc_d;
    logic                    ovf_int_q, ovf_int_d;
    logic signed [WIDTH-1:0] result_q, result_d;
    logic                    ovf_q, ovf_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    // Reciprocal table is a pure elaboration-time constant; entry 0 is unused.
    logic signed [WIDTH-1:0] recip_tbl [RecipDepth];
    for (genvar i = 0; i < RecipDepth; i++) begin : g_recip
        if (i == 0) begin : g_zero
            assign recip_tbl[i] = '0;
        end else begin : g_val
            assign recip_tbl[i] = WIDTH'((1 << FRAC) / i);
        end
    end

    logic signed [WIDTH-1:0]   mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] prod_sh;
    logic signed [WIDTH-1:0]   mul_sat;
    logic                      mul_ovf;
    logic [WIDTH:0]            sum;
    logic signed [WIDTH-1:0]   acc_sat;
    logic                      acc_ovf;
    logic                      add_en;

    always_comb begin
        mul_b   = (state_q == StMulC) ? recip_tbl[n_q] : x_q;
        prod    = {{WIDTH{t_q[WIDTH-1]}}, t_q} * {{WIDTH{mul_b[WIDTH-1]}}, mul_b};
        prod_sh = prod >>> FRAC;
        mul_ovf = (prod_sh > ProdMax) || (prod_sh < ProdMin);
        if (prod_sh > ProdMax) begin
            mul_sat = WordMax;
        end else if (prod_sh < ProdMin) begin
            mul_sat = WordMin;
        end else begin
            mul_sat = prod_sh[WIDTH-1:0];
        end

        // Overflow when the extra sign bit disagrees with the word's sign bit.
        sum     = {acc_q[WIDTH-1], acc_q} + {t_q[WIDTH-1], t_q};
        acc_ovf = sum[WIDTH] ^ sum[WIDTH-1];
        if (acc_ovf) begin
            acc_sat = sum[WIDTH] ? WordMin : WordMax;
        end else begin
            acc_sat = sum[WIDTH-1:0];
        end

        case (mode_q)
            2'd1:    add_en = ~n_q[0];
            2'd2:    add_en = n_q[0];
            default: add_en = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        mode_d    = mode_q;
        nlim_d    = nlim_q;
        n_d       = n_q;
        t_d       = t_q;
        acc_d     = acc_q;
        ovf_int_d = ovf_int_q;
        result_d  = result_q;
        ovf_d     = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    x_d    = x_in;
                    mode_d = mode;
                    if (terms_in == '0) begin
                        nlim_d = TW'(1);
                    end else if (terms_in > TW'(MAX_TERMS)) begin
                        nlim_d = TW'(MAX_TERMS);
                    end else begin
                        nlim_d = terms_in;
                    end
                    state_d = StInit;
                end
            end
            StInit: begin
                t_d       = One;
                n_d       = TW'(1);
                ovf_int_d = 1'b0;
                acc_d     = (mode_q == 2'd2) ? '0 : One;
                if (nlim_q == TW'(1)) begin
                    result_d = acc_d;
                    ovf_d    = 1'b0;
                    state_d  = StDone;
                end else begin
                    state_d = StMulX;
                end
            end
            StMulX: begin
                t_d       = mul_sat;
                ovf_int_d = ovf_int_q | mul_ovf;
                state_d   = StMulC;
            end
            StMulC: begin
                t_d       = mul_sat;
                ovf_int_d = ovf_int_q | mul_ovf;
                state_d   = StAcc;
            end
            StAcc: begin
                if (add_en) begin
                    acc_d     = acc_sat;
                    ovf_int_d = ovf_int_q | acc_ovf;
                end
                n_d = n_q + TW'(1);
                if (n_d == nlim_q) begin
                    result_d = acc_d;
                    ovf_d    = ovf_int_d;
                    state_d  = StDone;
                end else begin
                    state_d = StMulX;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            x_q       <= '0;
            mode_q    <= '0;
            nlim_q    <= '0;
            n_q       <= '0;
            t_q       <= '0;
            acc_q     <= '0;
            ovf_int_q <= 1'b0;
            result_q  <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            mode_q    <= mode_d;
            nlim_q    <= nlim_d;
            n_q       <= n_d;
            t_q       <= t_d;
            acc_q     <= acc_d;
            ovf_int_q <= ovf_int_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;

endmodule
